mc_core: RTL and testbench

MC_CORE -- requirements
Module: mc_core

---
 rtl/mc_core_pkg.sv | 109 ++++++++++
 rtl/mc_alu.sv | 39 +++
 rtl/mc_core.sv | 139 +++++++++++++
 tb/tb_mc_core.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_core_pkg.sv
// Shared definitions for the mc_core sequential integer core: opcodes,
// function codes, ALU operations, FSM states and the instruction decoder.
package mc_core_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_WB     = 2'd3
   } state_e;

   typedef struct packed {
      logic    legal;
      alu_op_e op;
      logic    use_imm;
      logic    use_rs1;
      logic    use_rs2;
   } dec_t;

   function automatic alu_op_e f3_op(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = ALU_SRL;
         F3_OR:   op = ALU_OR;
         F3_AND:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Opcode/funct legality only; register index range is checked by the core.
   function automatic dec_t decode(input logic [31:0] ins);
      dec_t       d;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      d.legal   = 1'b0;
      d.op      = ALU_ADD;
      d.use_imm = 1'b0;
      d.use_rs1 = 1'b0;
      d.use_rs2 = 1'b0;
      case (ins[6:0])
         OPC_OP: begin
            d.use_rs1 = 1'b1;
            d.use_rs2 = 1'b1;
            if (f7 == F7_BASE) begin
               d.legal = 1'b1;
               d.op    = f3_op(f3);
            end else if ((f7 == F7_ALT) && (f3 == F3_ADD)) begin
               d.legal = 1'b1;
               d.op    = ALU_SUB;
            end else if ((f7 == F7_ALT) && (f3 == F3_SR)) begin
               d.legal = 1'b1;
               d.op    = ALU_SRA;
            end else begin
               d.legal = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            d.use_rs1 = 1'b1;
            d.use_imm = 1'b1;
            d.op      = f3_op(f3);
            if (f3 == F3_SLL) begin
               d.legal = (f7 == F7_BASE);
            end else if (f3 == F3_SR) begin
               d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
               d.op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            end else begin
               d.legal = 1'b1;
            end
         end
         OPC_LUI: begin
            d.legal   = 1'b1;
            d.op      = ALU_PASS_B;
            d.use_imm = 1'b1;
         end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for mc_core; wraps modulo 2^XLEN, shifts use the low
// log2(XLEN) bits of b.
module mc_alu
   import mc_core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_e         op,
   output logic [XLEN-1:0] y
);

   localparam int SW = $clog2(XLEN);

   logic [SW-1:0] shamt_s;

   assign shamt_s = b[SW-1:0];

   // Operation select.
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:    y = a + b;
         ALU_SUB:    y = a - b;
         ALU_AND:    y = a & b;
         ALU_OR:     y = a | b;
         ALU_XOR:    y = a ^ b;
         ALU_SLT:    y = XLEN'($signed(a) < $signed(b));
         ALU_SLTU:   y = XLEN'(a < b);
         ALU_SLL:    y = a << shamt_s;
         ALU_SRL:    y = a >> shamt_s;
         ALU_SRA:    y = $unsigned($signed(a) >>> shamt_s);
         ALU_PASS_B: y = b;
         default:    y = '0;
      endcase
   end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle RV32I integer subset core: IDLE -> DECODE -> EXEC -> WB, one
// instruction in flight, inline NREG x XLEN register file.
module mc_core
   import mc_core_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic            instr_ready,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      res_rd,
   output logic            illegal
);

   localparam int RW = $clog2(NREG);

   state_e          state_r, state_nx_s;
   logic [31:0]     instr_r;
   logic [XLEN-1:0] regs_r [NREG];
   logic [XLEN-1:0] a_r, b_r, alu_y_s, rs1_val_s, rs2_val_s, imm_s;
   alu_op_e         op_r;
   logic [4:0]      rd_r, res_rd_r, rs1_s, rs2_s, rd_s;
   logic [XLEN-1:0] result_r;
   logic            res_valid_r, illegal_r;
   dec_t            dec_s;
   logic            legal_s;

   assign rd_s  = instr_r[11:7];
   assign rs1_s = instr_r[19:15];
   assign rs2_s = instr_r[24:20];

   // Decode, index range check, operand read and immediate generation.
   always_comb begin
      dec_s   = decode(instr_r);
      legal_s = dec_s.legal
                && (int'(rd_s) < NREG)
                && !(dec_s.use_rs1 && (int'(rs1_s) >= NREG))
                && !(dec_s.use_rs2 && (int'(rs2_s) >= NREG));
      rs1_val_s = (rs1_s == 5'd0) ? '0 : regs_r[rs1_s[RW-1:0]];
      rs2_val_s = (rs2_s == 5'd0) ? '0 : regs_r[rs2_s[RW-1:0]];
      if (instr_r[6:0] == OPC_LUI) begin
         imm_s = XLEN'($signed({instr_r[31:12], 12'h000}));
      end else begin
         imm_s = XLEN'($signed(instr_r[31:20]));
      end
   end

   mc_alu #(.XLEN(XLEN)) u_alu (
      .a  (a_r),
      .b  (b_r),
      .op (op_r),
      .y  (alu_y_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE:   state_nx_s = instr_valid ? S_DECODE : S_IDLE;
         S_DECODE: state_nx_s = legal_s ? S_EXEC : S_IDLE;
         S_EXEC:   state_nx_s = S_WB;
         S_WB:     state_nx_s = res_ready ? S_IDLE : S_WB;
         default:  state_nx_s = S_IDLE;
      endcase
   end

   // Datapath, result registers and register file; x0 is never written.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_r     <= 32'h0000_0000;
         a_r         <= '0;
         b_r         <= '0;
         op_r        <= ALU_ADD;
         rd_r        <= 5'd0;
         result_r    <= '0;
         res_rd_r    <= 5'd0;
         res_valid_r <= 1'b0;
         illegal_r   <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= '0;
         end
      end else begin
         illegal_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (instr_valid) begin
                  instr_r <= instr;
               end
            end
            S_DECODE: begin
               if (legal_s) begin
                  a_r  <= rs1_val_s;
                  b_r  <= dec_s.use_imm ? imm_s : rs2_val_s;
                  op_r <= dec_s.op;
                  rd_r <= rd_s;
               end else begin
                  illegal_r <= 1'b1;
               end
            end
            S_EXEC: begin
               result_r    <= alu_y_s;
               res_rd_r    <= rd_r;
               res_valid_r <= 1'b1;
            end
            S_WB: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
                  if (res_rd_r != 5'd0) begin
                     regs_r[res_rd_r[RW-1:0]] <= result_r;
                  end
               end
            end
            default: res_valid_r <= 1'b0;
         endcase
      end
   end

   assign instr_ready = (state_r == S_IDLE);
   assign res_valid   = res_valid_r;
   assign result      = result_r;
   assign res_rd      = res_rd_r;
   assign illegal     = illegal_r;

endmodule

// File: tb/tb_mc_core.sv
// Directed scoreboard bench for mc_core: a 32/32 instance and a 64/16 instance
// share clock, reset, instr and res_ready; each has its own instr_valid.
module tb_mc_core;

   localparam logic [6:0] OPI = 7'h13;

   typedef struct {
      bit          ill;
      logic [63:0] res;
      logic [4:0]  rd;
   } exp_t;

   logic        clk, reset, res_ready, valid_a, valid_b;
   logic [31:0] instr;
   logic        ready_a, rv_a, ill_a, ready_b, rv_b, ill_b;
   logic [31:0] res_a;
   logic [63:0] res_b;
   logic [4:0]  rd_a, rd_b;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   mc_core #(.XLEN(32), .NREG(32)) u_dut_a (
      .clk(clk), .reset(reset), .instr_valid(valid_a), .instr(instr),
      .instr_ready(ready_a), .res_valid(rv_a), .res_ready(res_ready),
      .result(res_a), .res_rd(rd_a), .illegal(ill_a)
   );

   mc_core #(.XLEN(64), .NREG(16)) u_dut_b (
      .clk(clk), .reset(reset), .instr_valid(valid_b), .instr(instr),
      .instr_ready(ready_b), .res_valid(rv_b), .res_ready(res_ready),
      .result(res_b), .res_rd(rd_b), .illegal(ill_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, OPI};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic sample(input bit sel, output logic ov, output logic oi, output logic ordy,
                         output logic [63:0] ores, output logic [4:0] ord);
      if (sel) begin
         ov = rv_b; oi = ill_b; ordy = ready_b; ores = res_b; ord = rd_b;
      end else begin
         ov = rv_a; oi = ill_a; ordy = ready_a; ores = {32'h0, res_a}; ord = rd_a;
      end
   endtask

   // Issue one instruction at a negedge in IDLE, then check its outcome.
   task automatic run(input bit sel, input logic [31:0] ins, input bit e_ill,
                      input logic [63:0] e_res, input logic [4:0] e_rd, input int stall);
      exp_t        e, g;
      int          cyc;
      bit          done;
      logic        ov, oi, ordy;
      logic [63:0] ores;
      logic [4:0]  ord;
      e.ill = e_ill; e.res = e_res; e.rd = e_rd;
      exp_q.push_back(e);
      sample(sel, ov, oi, ordy, ores, ord);
      chk("pre_ready", 64'(ordy), 64'd1);
      instr     = ins;
      res_ready = (stall == 0);
      if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0; valid_b = 1'b0; instr = 32'h0;
      cyc = 0; done = 1'b0;
      while (!done && cyc < 8) begin
         @(negedge clk);
         cyc++;
         sample(sel, ov, oi, ordy, ores, ord);
         if (ov || oi) done = 1'b1;
      end
      chk("outcome_seen", 64'(done), 64'd1);
      g = exp_q.pop_front();
      chk("illegal", 64'(oi), 64'(g.ill));
      chk("latency", 64'(cyc), g.ill ? 64'd2 : 64'd3);
      chk("excl", 64'(ov && oi), 64'd0);
      if (!g.ill) begin
         chk("result", ores, g.res);
         chk("res_rd", 64'(ord), 64'(g.rd));
      end
      if (stall > 0) begin
         instr = enc_i(12'd77, 5'd0, 3'd0, 5'd24);
         if (sel) valid_b = 1'b1; else valid_a = 1'b1;
         repeat (stall) begin
            @(negedge clk);
            sample(sel, ov, oi, ordy, ores, ord);
            chk("stall_result", ores, g.res);
            chk("stall_valid", 64'(ov), 64'd1);
            chk("stall_ready", 64'(ordy), 64'd0);
         end
         valid_a = 1'b0; valid_b = 1'b0; res_ready = 1'b1;
      end
      @(negedge clk);
      sample(sel, ov, oi, ordy, ores, ord);
      chk("post_valid", 64'(ov), 64'd0);
      chk("post_illegal", 64'(oi), 64'd0);
      chk("post_ready", 64'(ordy), 64'd1);
   endtask

   task automatic ok(input bit sel, input logic [31:0] ins, input logic [63:0] r, input logic [4:0] rd);
      run(sel, ins, 1'b0, r, rd, 0);
   endtask

   task automatic bad(input bit sel, input logic [31:0] ins);
      run(sel, ins, 1'b1, 64'd0, 5'd0, 0);
   endtask

   initial begin
      reset = 1'b0; res_ready = 1'b1; valid_a = 1'b0; valid_b = 1'b0; instr = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_valid_a", 64'(rv_a), 64'd0);
      chk("rst_ill_a", 64'(ill_a), 64'd0);
      chk("rst_result_a", 64'(res_a), 64'd0);
      chk("rst_rd_a", 64'(rd_a), 64'd0);
      chk("rst_result_b", res_b, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready_a", 64'(ready_a), 64'd1);
      chk("rst_ready_b", 64'(ready_b), 64'd1);

      // 32-bit instance: arithmetic, logic, compares, shifts, LUI.
      ok(0, enc_i(12'd5,   5'd0, 3'd0, 5'd1), 64'h5, 5'd1);
      ok(0, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 64'hFFFF_FFFF, 5'd1);
      ok(0, enc_i(12'h001, 5'd1, 3'd5, 5'd2), 64'h7FFF_FFFF, 5'd2);
      ok(0, enc_i(12'hFF0, 5'd0, 3'd0, 5'd4), 64'hFFFF_FFF0, 5'd4);
      ok(0, enc_i(12'h402, 5'd4, 3'd5, 5'd3), 64'hFFFF_FFFC, 5'd3);
      ok(0, enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd5), 64'h8000_0001, 5'd5);
      ok(0, enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd6), 64'h7FFF_FFFE, 5'd6);
      ok(0, enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd7), 64'h1, 5'd7);
      ok(0, enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd8), 64'h0, 5'd8);
      ok(0, enc_i(12'hFFF, 5'd0, 3'd3, 5'd9), 64'h1, 5'd9);
      ok(0, enc_r(7'h00, 5'd1, 5'd2, 3'd4, 5'd10), 64'h8000_0000, 5'd10);
      ok(0, enc_r(7'h00, 5'd2, 5'd4, 3'd7, 5'd11), 64'h7FFF_FFF0, 5'd11);
      ok(0, enc_r(7'h00, 5'd4, 5'd5, 3'd6, 5'd12), 64'hFFFF_FFF1, 5'd12);
      ok(0, enc_i(12'd33, 5'd0, 3'd0, 5'd14), 64'd33, 5'd14);
      ok(0, enc_i(12'd1,  5'd0, 3'd0, 5'd15), 64'd1, 5'd15);
      ok(0, enc_r(7'h00, 5'd14, 5'd15, 3'd1, 5'd13), 64'h2, 5'd13);
      ok(0, enc_r(7'h20, 5'd14, 5'd5, 3'd5, 5'd16), 64'hC000_0000, 5'd16);
      ok(0, enc_r(7'h00, 5'd14, 5'd5, 3'd5, 5'd17), 64'h4000_0000, 5'd17);
      ok(0, {20'hABCDE, 5'd18, 7'h37}, 64'hABCD_E000, 5'd18);
      ok(0, enc_i(12'h0F0, 5'd12, 3'd7, 5'd19), 64'hF0, 5'd19);
      ok(0, enc_i(12'h123, 5'd0, 3'd6, 5'd19), 64'h123, 5'd19);
      ok(0, enc_i(12'h0F0, 5'd1, 3'd4, 5'd20), 64'hFFFF_FF0F, 5'd20);
      ok(0, enc_i(12'h000, 5'd1, 3'd2, 5'd21), 64'h1, 5'd21);
      ok(0, enc_i(12'h01F, 5'd15, 3'd1, 5'd22), 64'h8000_0000, 5'd22);

      // Unsupported encodings.
      bad(0, {12'd0, 5'd0, 3'd2, 5'd1, 7'h03});
      bad(0, enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3));
      bad(0, enc_i(12'h401, 5'd1, 3'd1, 5'd3));
      bad(0, enc_i(12'h201, 5'd1, 3'd5, 5'd3));

      // x0 behaviour, then WB stall with stray instructions offered.
      ok(0, enc_i(12'd7, 5'd0, 3'd0, 5'd0), 64'h7, 5'd0);
      ok(0, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd3), 64'h0, 5'd3);
      run(0, enc_i(12'd100, 5'd0, 3'd0, 5'd23), 1'b0, 64'd100, 5'd23, 5);
      ok(0, enc_r(7'h00, 5'd24, 5'd23, 3'd0, 5'd25), 64'd100, 5'd25);

      // Reset while the instruction is in EXEC.
      instr = enc_i(12'd55, 5'd0, 3'd0, 5'd1);
      valid_a = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_exec_valid", 64'(rv_a), 64'd0);
      chk("rst_exec_result", 64'(res_a), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("rst_exec_no_valid", 64'(rv_a), 64'd0);
         chk("rst_exec_ready", 64'(ready_a), 64'd1);
      end
      ok(0, enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd26), 64'h0, 5'd26);

      // 64-bit, 16-register instance.
      ok(1, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
      ok(1, enc_i(12'h001, 5'd1, 3'd5, 5'd2), 64'h7FFF_FFFF_FFFF_FFFF, 5'd2);
      ok(1, {20'h80000, 5'd3, 7'h37}, 64'hFFFF_FFFF_8000_0000, 5'd3);
      bad(1, enc_i(12'd1, 5'd0, 3'd0, 5'd20));
      bad(1, enc_r(7'h00, 5'd0, 5'd17, 3'd0, 5'd4));
      bad(1, enc_r(7'h00, 5'd31, 5'd1, 3'd0, 5'd5));
      ok(1, enc_r(7'h00, 5'd0, 5'd2, 3'd0, 5'd6), 64'h7FFF_FFFF_FFFF_FFFF, 5'd6);
      ok(1, enc_r(7'h00, 5'd0, 5'd15, 3'd0, 5'd7), 64'h0, 5'd7);
      ok(1, enc_i(12'd33, 5'd0, 3'd0, 5'd10), 64'd33, 5'd10);
      ok(1, enc_i(12'd1,  5'd0, 3'd0, 5'd12), 64'd1, 5'd12);
      ok(1, enc_r(7'h00, 5'd10, 5'd12, 3'd1, 5'd11), 64'h0000_0002_0000_0000, 5'd11);
      ok(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 64'h7FFF_FFFF_FFFF_FFFE, 5'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
